// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, parity, stop, with a one-entry
// holding buffer. Define UART_TX_TWO_STOP_EN to append a second stop bit (12-period frame).
module uart_tx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
`ifdef UART_TX_TWO_STOP_EN
    StStop,
    StStop2
`else
    StStop
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       frame_end;
  logic       load_frame;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    frame_end  = 1'b0;
    load_frame = 1'b0;

    // Accept and hand-off are mutually exclusive: both are qualified by buf_full_q.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (buf_full_q) begin
            load_frame = 1'b1;
          end
        end
        StStart: begin
          tx_d    = shift_q[0];
          cnt_d   = 3'd0;
          state_d = StData;
        end
        StData: begin
          if (cnt_q == 3'd7) begin
            tx_d    = (^shift_q) ^ PARITY_ODD;
            state_d = StParity;
          end else begin
            tx_d  = shift_q[cnt_q + 3'd1];
            cnt_d = cnt_q + 3'd1;
          end
        end
        StParity: begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
`ifdef UART_TX_TWO_STOP_EN
        StStop: begin
          state_d = StStop2;
        end
        StStop2: begin
          frame_end = 1'b1;
        end
`else
        StStop: begin
          frame_end = 1'b1;
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Last stop period ends: chain straight into a queued byte, otherwise go idle.
    if (frame_end) begin
      done_d = 1'b1;
      if (buf_full_q) begin
        load_frame = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end

    if (load_frame) begin
      tx_d       = 1'b0;
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      state_d    = StStart;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      buf_q      <= 8'h00;
      buf_full_q <= 1'b0;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !buf_full_q;
  assign busy     = (state_q != StIdle);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued by the driver and a line monitor
// predicts every bit period from the frame rules, checking an even- and an odd-parity DUT.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NBITS = 12;
  localparam logic [11:0] A5_EXP = 12'hD4A;
`else
  localparam int NBITS = 11;
  localparam logic [11:0] A5_EXP = 12'h54A;
`endif

  typedef struct {
    logic [7:0] data;
    int         acc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, busy, tx_done;
  logic       tx_ready_o, tx_odd, busy_o, tx_done_o;

  ent_t       q[$];
  ent_t       ent;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pos = -1;
  int         tick_cnt = 0;
  int         prev_start = 0;
  int         last_gap = 0;
  int         dut_done_cnt = 0;
  int         tick_mode = 2;
  int         tick_per = 4;
  int         tcnt = 0;
  int         sent_ok = 0;
  logic [7:0] cur = 8'h00;
  logic [11:0] obs_bits = '0;
  logic [11:0] last_bits = '0;
  logic       obs_par_odd = 1'b0;
  logic       last_par_odd = 1'b0;
  logic       line_e = 1'b1;
  logic       line_o = 1'b1;
  logic       exp_done = 1'b0;

  uart_tx #(.PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(.PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_o), .tx(tx_odd), .busy(busy_o), .tx_done(tx_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line level of bit period p of a frame carrying byte d.
  function automatic logic fbit(input logic [7:0] d, input int p, input logic odd);
    if (p == 0) return 1'b0;
    if (p <= 8) return d[3'(p - 1)];
    if (p == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Baud tick source: 0 = off, 1 = held high, 2 = periodic, 3 = random.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_mode == 0) baud_tick = 1'b0;
      else if (tick_mode == 1) baud_tick = 1'b1;
      else if (tick_mode == 3) baud_tick = ($urandom_range(0, 3) == 0);
      else if (tcnt >= tick_per - 1) begin
        baud_tick = 1'b1;
        tcnt = 0;
      end else begin
        baud_tick = 1'b0;
        tcnt++;
      end
    end
  end

  // Monitor: inputs still hold their pre-edge values at posedge+1.
  always @(posedge clk) begin
    cyc++;
    #1;
    exp_done = 1'b0;
    if (rst) begin
      pos    = -1;
      line_e = 1'b1;
      line_o = 1'b1;
    end else if (baud_tick) begin
      tick_cnt++;
      if (pos >= 0) pos++;
      if (pos == NBITS) begin
        exp_done     = 1'b1;
        last_bits    = obs_bits;
        last_par_odd = obs_par_odd;
        pos          = -1;
      end
      if (pos < 0 && q.size() > 0 && q[0].acc < cyc) begin
        ent        = q.pop_front();
        cur        = ent.data;
        pos        = 0;
        obs_bits   = '0;
        last_gap   = tick_cnt - prev_start;
        prev_start = tick_cnt;
      end
      line_e = (pos >= 0) ? fbit(cur, pos, 1'b0) : 1'b1;
      line_o = (pos >= 0) ? fbit(cur, pos, 1'b1) : 1'b1;
      if (pos >= 0) begin
        obs_bits[pos] = tx;
        if (pos == 9) obs_par_odd = tx_odd;
      end
    end
    if (tx_done === 1'b1) dut_done_cnt++;
    chk("tx", 32'(tx), 32'(line_e));
    chk("tx_odd", 32'(tx_odd), 32'(line_o));
    chk("tx_ready", 32'(tx_ready), 32'(q.size() == 0));
    chk("busy", 32'(busy), 32'(pos >= 0));
    chk("tx_done", 32'(tx_done), 32'(exp_done));
    chk("tx_done_odd", 32'(tx_done_o), 32'(exp_done));
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    ent_t e;
    tx_valid = 1'b1;
    tx_data  = $urandom;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      tx_data = $urandom;
      n++;
    end
    if (!tx_ready) begin
      chk("accept_timeout", 32'(tx_ready), 32'd1);
    end else begin
      tx_data = b;
      e.data  = b;
      e.acc   = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || pos >= 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size() == 0 && pos < 0), 32'd1);
  endtask

  task automatic wait_ticks(input int k);
    int t0 = tick_cnt;
    int n  = 0;
    while (tick_cnt < t0 + k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tick_budget", 32'(tick_cnt >= t0 + k), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_ticks(20);
    chk("idle_no_done", 32'(dut_done_cnt), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);

    d0 = dut_done_cnt;
    send(8'hA5);
    sent_ok++;
    wait_idle();
    chk("a5_frame", 32'(last_bits), 32'(A5_EXP));
    chk("a5_done", 32'(dut_done_cnt - d0), 32'd1);

    send(8'h07);
    sent_ok++;
    wait_idle();
    chk("07_data", 32'(last_bits[8:1]), 32'h07);
    chk("07_par_even", 32'(last_bits[9]), 32'd1);
    chk("07_par_odd", 32'(last_par_odd), 32'd0);

    d0 = dut_done_cnt;
    send(8'h81);
    send(8'h3C);
    sent_ok += 2;
    wait_idle();
    chk("b2b_gap", 32'(last_gap), 32'(NBITS));
    chk("b2b_data", 32'(last_bits[8:1]), 32'h3C);
    chk("b2b_done", 32'(dut_done_cnt - d0), 32'd2);

    d0 = dut_done_cnt;
    send(8'h55);
    send(8'hFF);
    n = 0;
    while (pos != 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit5", 32'(pos), 32'd5);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    wait_ticks(30);
    chk("rst_no_done", 32'(dut_done_cnt - d0), 32'd0);

    tick_mode = 1;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom));
      sent_ok++;
    end
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        tick_mode = $urandom_range(2, 3);
        tick_per  = $urandom_range(1, 6);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
      send(8'($urandom));
      sent_ok++;
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("total_done", 32'(dut_done_cnt), 32'(sent_ok));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide UART transmitter, the transmit end of the team's UART link; pairs with the existing UART receiver.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
- Bit timing comes from the shared external baud_tick generator (one-cycle pulse per bit period).
- Upstream side is a valid/ready byte interface with a one-entry holding buffer, so a new byte can be queued while the current frame is on the line.

Parameters:
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of the 8 data bits, which is what the receiver checks); 1 = odd parity (inverted XOR).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- baud_tick  input  1  one-clk pulse per bit period
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  holding buffer empty; byte accepted when tx_valid && tx_ready
- tx  output  1  serial line, idle high, registered
- busy  output  1  a frame is in progress (state != IDLE)
- tx_done  output  1  one-clk pulse when the final stop bit period ends

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0. State=IDLE, holding buffer empty, shift register=0, bit counter=0.
- The reset is "Already decided": one clock (clk); reset rst is synchronous and active-high.
- Reset mid-frame: tx returns to 1 on the next edge, the frame is aborted, the holding buffer is discarded and no tx_done is issued.
- Holding buffer:
  - On an edge with tx_valid && tx_ready, the buffer loads tx_data; buf_full=1 and tx_ready=0 from the next cycle.
  - tx_ready = !buf_full.
  - The buffer is emptied only on the cycle its contents move to the shift register. tx_ready rises on the next cycle.
- tx changes only on clk edges where baud_tick=1. Between ticks all state holds, so each bit lasts exactly one baud period.
- The state encodes which bit is currently on the line:
  - IDLE, tick, buffer full: tx<=0, shift<=buffer, buffer emptied, go to START.
  - IDLE, tick, buffer empty: tx stays 1, stay in IDLE.
  - START, tick: tx<=shift[0], cnt<=0, go to DATA.
  - DATA, tick, cnt<7: tx<=shift[cnt+1], cnt<=cnt+1.
  - DATA, tick, cnt==7: tx<=(^shift)^PARITY_ODD, go to PARITY.
  - PARITY, tick: tx<=1, go to STOP.
  - STOP, tick: tx_done=1 for that cycle.
    - Buffer full: tx<=0, load shift from the buffer, go to START (back-to-back frames, no extra idle).
    - Buffer empty: tx stays 1, go to IDLE.
- Frame length: 11 baud periods. Back-to-back throughput: 1 byte per 11 ticks.
- Latency: a byte accepted in IDLE starts its start bit on the first baud_tick after buf_full=1.
- A tick arriving on the same cycle as an accept does not start the frame; the frame starts on the next tick.
- baud_tick held high continuously is legal: one bit per clk.
- tx_valid while tx_ready=0: ignored, tx_data not sampled. Upstream must hold the byte until it is accepted.
- busy=1 from the cycle after START is entered until the cycle after STOP→IDLE.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: a STOP2 state is added.
  - STOP tick: tx stays 1, go to STOP2, no tx_done.
  - STOP2 tick: tx_done pulses; next-frame/IDLE rules are the same as STOP without the macro.
  - Frame length is 12 periods.
- Undefined: 1 stop bit, 11-period frame as described above.

Test Plan:
- Reset, then 20 ticks with tx_valid=0 → tx=1, tx_ready=1, busy=0, tx_done never pulses.
- Send 0xA5 (PARITY_ODD=0) → tx over successive tick periods = 0,1,0,1,0,0,1,0,1,0(parity),1(stop); tx_done pulses once on the 11th tick.
- Send 0x07 with PARITY_ODD=0 → parity bit 1; with PARITY_ODD=1 → parity bit 0. Loopback into the receiver gives data_out=0x07, p_err=0 (even case).
- Queue 0x3C during the frame for 0x81 → tx_ready low until 0x3C loads at the 0x81 stop tick; start bit of 0x3C directly follows 1 stop period; 22 periods total; tx_done pulses twice.
- Assert rst at the 5th data bit of 0x55 with 0xFF buffered → tx=1 next cycle, tx_ready=1, busy=0, no tx_done; 0xFF is never transmitted.
- With UART_TX_TWO_STOP_EN defined, send 0x00 → line 0,0×8,0(parity),1,1; tx_done pulses on the 12th tick.
